// File: rtl/mpy_mac_pipe.sv
// Pipelined WIDTH x WIDTH multiplier-accumulator with a selectable product latency and CE stall.
// It also has a dual half-width lane mode and a saturating or wrapping two's-complement accumulator.
module mpy_mac_pipe #(
   parameter int WIDTH     = 16,
   parameter int PIPE      = 2,
   parameter int ACC_WIDTH = 40,
   parameter int SAT_EN    = 1
) (
   input  logic                 clk,
   input  logic                 RSTN,
   input  logic                 CE,
   input  logic                 IN_VALID,
   input  logic                 ASGND,
   input  logic                 BSGND,
   input  logic                 SPLIT_MODE,
   input  logic                 ACC_EN,
   input  logic                 ACC_CLR,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   output logic                 OUT_VALID,
   output logic [2*WIDTH-1:0]   P,
   output logic                 ACC_VALID,
   output logic [ACC_WIDTH-1:0] ACC,
   output logic                 ACC_OVF
);

   localparam int H  = WIDTH / 2;
   localparam int NP = (PIPE > 1) ? PIPE - 1 : 1;

   typedef struct packed {
      logic asg;
      logic bsg;
      logic split;
      logic acc_en;
      logic acc_clr;
   } side_t;

   side_t              w_in_side;
   logic               w_mv;
   logic [WIDTH-1:0]   w_ma;
   logic [WIDTH-1:0]   w_mb;
   side_t              w_ms;

   assign w_in_side = {ASGND, BSGND, SPLIT_MODE, ACC_EN, ACC_CLR};

   // With PIPE=1 the operand register and product register are the same stage.
   generate
      if (PIPE > 1) begin : g_opreg
         logic             r_ov;
         logic [WIDTH-1:0] r_oa;
         logic [WIDTH-1:0] r_ob;
         side_t            r_os;

         always_ff @(posedge clk) begin
            if (!RSTN) begin
               r_ov <= 1'b0;
               r_oa <= '0;
               r_ob <= '0;
               r_os <= '0;
            end else if (CE) begin
               r_ov <= IN_VALID;
               if (IN_VALID) begin
                  r_oa <= A;
                  r_ob <= B;
                  r_os <= w_in_side;
               end
            end
         end

         assign w_mv = r_ov;
         assign w_ma = r_oa;
         assign w_mb = r_ob;
         assign w_ms = r_os;
      end else begin : g_noopreg
         assign w_mv = IN_VALID;
         assign w_ma = A;
         assign w_mb = B;
         assign w_ms = w_in_side;
      end
   endgenerate

   // Operands are extended to the result width so the modular product is exact for any sign mix.
   logic [2*WIDTH-1:0] w_fa, w_fb, w_fp, w_prod;
   logic [WIDTH-1:0]   w_la_lo, w_lb_lo, w_la_hi, w_lb_hi, w_lp_lo, w_lp_hi;

   assign w_fa    = {{WIDTH{w_ms.asg & w_ma[WIDTH-1]}}, w_ma};
   assign w_fb    = {{WIDTH{w_ms.bsg & w_mb[WIDTH-1]}}, w_mb};
   assign w_fp    = w_fa * w_fb;
   assign w_la_lo = {{H{w_ms.asg & w_ma[H-1]}}, w_ma[H-1:0]};
   assign w_lb_lo = {{H{w_ms.bsg & w_mb[H-1]}}, w_mb[H-1:0]};
   assign w_la_hi = {{H{w_ms.asg & w_ma[WIDTH-1]}}, w_ma[WIDTH-1:H]};
   assign w_lb_hi = {{H{w_ms.bsg & w_mb[WIDTH-1]}}, w_mb[WIDTH-1:H]};
   assign w_lp_lo = w_la_lo * w_lb_lo;
   assign w_lp_hi = w_la_hi * w_lb_hi;
   assign w_prod  = w_ms.split ? {w_lp_hi, w_lp_lo} : w_fp;

   logic               r_pv [NP];
   logic [2*WIDTH-1:0] r_pd [NP];
   side_t              r_ps [NP];

   always_ff @(posedge clk) begin
      if (!RSTN) begin
         for (int unsigned i = 0; i < NP; i++) begin
            r_pv[i] <= 1'b0;
            r_pd[i] <= '0;
            r_ps[i] <= '0;
         end
      end else if (CE) begin
         r_pv[0] <= w_mv;
         if (w_mv) begin
            r_pd[0] <= w_prod;
            r_ps[0] <= w_ms;
         end
         for (int unsigned i = 1; i < NP; i++) begin
            r_pv[i] <= r_pv[i-1];
            if (r_pv[i-1]) begin
               r_pd[i] <= r_pd[i-1];
               r_ps[i] <= r_ps[i-1];
            end
         end
      end
   end

   side_t                w_as;
   logic [2*WIDTH-1:0]   w_p;
   logic                 w_ext;
   logic [ACC_WIDTH-1:0] w_op_full, w_op_lo, w_op_hi, w_op, w_acc_add;
   logic [ACC_WIDTH:0]   w_sum;
   logic                 w_ovf;
   logic [ACC_WIDTH-1:0] r_acc;
   logic                 r_accv;
   logic                 r_ovf;

   assign w_as      = r_ps[NP-1];
   assign w_p       = r_pd[NP-1];
   assign w_ext     = w_as.asg | w_as.bsg;
   assign w_op_full = {{(ACC_WIDTH-2*WIDTH){w_ext & w_p[2*WIDTH-1]}}, w_p};
   assign w_op_lo   = {{(ACC_WIDTH-WIDTH){w_ext & w_p[WIDTH-1]}}, w_p[WIDTH-1:0]};
   assign w_op_hi   = {{(ACC_WIDTH-WIDTH){w_ext & w_p[2*WIDTH-1]}}, w_p[2*WIDTH-1:WIDTH]};
   assign w_op      = w_as.split ? (w_op_lo + w_op_hi) : w_op_full;
   assign w_sum     = {r_acc[ACC_WIDTH-1], r_acc} + {w_op[ACC_WIDTH-1], w_op};
   assign w_ovf     = w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1];

   always_comb begin
      w_acc_add = w_sum[ACC_WIDTH-1:0];
      if (w_ovf && (SAT_EN != 0)) begin
         w_acc_add = w_sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                      : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end
   end

   always_ff @(posedge clk) begin
      if (!RSTN) begin
         r_accv <= 1'b0;
         r_acc  <= '0;
         r_ovf  <= 1'b0;
      end else if (CE) begin
         r_accv <= r_pv[NP-1];
         if (r_pv[NP-1]) begin
            case ({w_as.acc_clr, w_as.acc_en})
               2'b11: begin
                  r_acc <= w_op;
                  r_ovf <= 1'b0;
               end
               2'b10: begin
                  r_acc <= '0;
                  r_ovf <= 1'b0;
               end
               2'b01: begin
                  r_acc <= w_acc_add;
                  if (w_ovf) r_ovf <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   assign OUT_VALID = r_pv[NP-1];
   assign P         = r_pd[NP-1];
   assign ACC_VALID = r_accv;
   assign ACC       = r_acc;
   assign ACC_OVF   = r_ovf;

endmodule
